// File: rtl/load_store_sequencer_if.sv
// Control bundle between the load/store sequencer and the Datapath.
//   run, IR            : Datapath/operator -> sequencer
//   PCout ... BAout    : control strobes, sequencer -> Datapath
//   done/halted/illegal/step : sequencer status
// master = sequencer side, slave = Datapath side.
interface load_store_sequencer_if #(
    parameter int IR_WIDTH = 32
);
    logic                run;
    logic [IR_WIDTH-1:0] IR;

    logic PCout, PCin, IncPC;
    logic MARin, MDRin, MDRout, MDMuxread;
    logic RAMread, RAMwrite;
    logic IRin, Yin, Zlowin, Zlowout, CSEout, ADD;
    logic Gra, Grb, Rin, Rout, BAout;

    logic       done;
    logic       halted;
    logic       illegal;
    logic [3:0] step;

    modport master (
        input  run, IR,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
               RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout, ADD,
               Gra, Grb, Rin, Rout, BAout, done, halted, illegal, step
    );

    modport slave (
        output run, IR,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
               RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout, ADD,
               Gra, Grb, Rin, Rout, BAout, done, halted, illegal, step
    );
endinterface

// File: rtl/load_store_sequencer.sv
// Hardwired control unit for the Datapath: fetches, decodes and sequences
// ld / ldi / st, plus nop and halt, one control step per clock.
// State advances on the falling edge of clock so every strobe is settled
// well before the Datapath's rising edge.
// Ports:
//   clock : sequencer clock (falling edge active)
//   clear : synchronous active-high reset, sampled on the falling edge
//   bus   : load_store_sequencer_if.master -- run/IR in, strobes and
//           done/halted/illegal/step out (all registered)
module load_store_sequencer #(
    parameter int         IR_WIDTH = 32,
    parameter int         MEM_WAIT = 0,
    parameter logic [4:0] OP_LD    = 5'b00000,
    parameter logic [4:0] OP_LDI   = 5'b00001,
    parameter logic [4:0] OP_ST    = 5'b00010,
    parameter logic [4:0] OP_NOP   = 5'b11010,
    parameter logic [4:0] OP_HALT  = 5'b11011
) (
    input  logic                   clock,
    input  logic                   clear,
    load_store_sequencer_if.master bus
);

    // Step states share their encoding with the step output; IDLE shares 15.
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd14,
        S_IDLE = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        C_LD, C_LDI, C_ST, C_NOP, C_HALT, C_ILL
    } op_e;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc;
        logic mar_in, mdr_in, mdr_out, mdmux_read;
        logic ram_read, ram_write;
        logic ir_in, y_in, zlow_in, zlow_out, cse_out, add;
        logic gra, grb, r_in, r_out, ba_out;
        logic done;
    } ctl_t;

    localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT);

    state_e     state, state_nxt;
    op_e        op, op_nxt, ir_op;
    logic [2:0] wcnt, wcnt_nxt;
    logic       illegal_q, ill_nxt;
    logic       boundary;
    ctl_t       ctl_q;
    logic       halted_q;
    logic [3:0] step_q;

    function automatic op_e decode_op(input logic [4:0] opc);
        op_e o;
        if (opc == OP_LD)        o = C_LD;
        else if (opc == OP_LDI)  o = C_LDI;
        else if (opc == OP_ST)   o = C_ST;
        else if (opc == OP_NOP)  o = C_NOP;
        else if (opc == OP_HALT) o = C_HALT;
        else                     o = C_ILL;
        return o;
    endfunction

    // Strobes for a given step. RAM states use the wait counter to tell the
    // first cycle (counter still at its load value) from the last (counter 0).
    function automatic ctl_t ctl_decode(input state_e s, input op_e o, input logic [2:0] wc);
        ctl_t c;
        c = '0;
        case (s)
            S_T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlow_in = 1'b1;
            end
            S_T1: begin
                c.mdmux_read = 1'b1;
                c.ram_read   = 1'b1;
                c.zlow_out   = (wc == WAIT_LD);
                c.pc_in      = (wc == WAIT_LD);
                c.mdr_in     = (wc == 3'd0);
            end
            S_T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1;
            end
            S_T3: begin
                if (o inside {C_LD, C_LDI, C_ST}) begin
                    c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
                end else begin
                    c.done = 1'b1;   // nop, halt and unknown opcodes end here
                end
            end
            S_T4: begin
                c.cse_out = 1'b1; c.add = 1'b1; c.zlow_in = 1'b1;
            end
            S_T5: begin
                c.zlow_out = 1'b1;
                if (o == C_LDI) begin
                    c.gra = 1'b1; c.r_in = 1'b1; c.done = 1'b1;
                end else begin
                    c.mar_in = 1'b1;
                end
            end
            S_T6: begin
                if (o == C_ST) begin
                    c.gra = 1'b1; c.r_out = 1'b1; c.ram_write = 1'b1;
                    c.done = (wc == 3'd0);
                end else begin
                    c.mdmux_read = 1'b1; c.ram_read = 1'b1;
                    c.mdr_in = (wc == 3'd0);
                end
            end
            S_T7: begin
                c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; c.done = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // IR has been loaded by the Datapath at the rising edge inside T2, so it
    // is sampled on the falling edge that leaves T2.
    assign ir_op = decode_op(bus.IR[IR_WIDTH-1 -: 5]);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        op_nxt    = op;
        ill_nxt   = illegal_q;
        boundary  = 1'b0;
        case (state)
            S_IDLE: if (bus.run) state_nxt = S_T0;
            S_T0: begin
                state_nxt = S_T1;
                wcnt_nxt  = WAIT_LD;
            end
            S_T1: begin
                if (wcnt == 3'd0) state_nxt = S_T2;
                else              wcnt_nxt  = wcnt - 3'd1;
            end
            S_T2: begin
                state_nxt = S_T3;
                op_nxt    = ir_op;
                if (ir_op == C_ILL) ill_nxt = 1'b1;
            end
            S_T3: begin
                case (op)
                    C_LD, C_LDI, C_ST: state_nxt = S_T4;
                    C_HALT:            state_nxt = S_HALT;
                    default:           boundary  = 1'b1;
                endcase
            end
            S_T4: state_nxt = S_T5;
            S_T5: begin
                if (op == C_LDI) begin
                    boundary = 1'b1;
                end else begin
                    state_nxt = S_T6;
                    wcnt_nxt  = WAIT_LD;
                end
            end
            S_T6: begin
                if (wcnt != 3'd0) wcnt_nxt  = wcnt - 3'd1;
                else if (op == C_LD) state_nxt = S_T7;
                else                 boundary  = 1'b1;
            end
            S_T7:   boundary  = 1'b1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        // run only matters between instructions
        if (boundary) state_nxt = bus.run ? S_T0 : S_IDLE;
    end

    // Outputs are decoded from the next state and registered with it, so
    // they are a pure function of the state register seen by the Datapath.
    always_ff @(negedge clock) begin
        if (clear) begin
            state     <= S_IDLE;
            wcnt      <= 3'd0;
            op        <= C_NOP;
            illegal_q <= 1'b0;
            ctl_q     <= '0;
            halted_q  <= 1'b0;
            step_q    <= 4'hF;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            op        <= op_nxt;
            illegal_q <= ill_nxt;
            ctl_q     <= ctl_decode(state_nxt, op_nxt, wcnt_nxt);
            halted_q  <= (state_nxt == S_HALT);
            step_q    <= (state_nxt inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7})
                         ? 4'(state_nxt) : 4'hF;
        end
    end

    assign bus.PCout     = ctl_q.pc_out;
    assign bus.PCin      = ctl_q.pc_in;
    assign bus.IncPC     = ctl_q.inc_pc;
    assign bus.MARin     = ctl_q.mar_in;
    assign bus.MDRin     = ctl_q.mdr_in;
    assign bus.MDRout    = ctl_q.mdr_out;
    assign bus.MDMuxread = ctl_q.mdmux_read;
    assign bus.RAMread   = ctl_q.ram_read;
    assign bus.RAMwrite  = ctl_q.ram_write;
    assign bus.IRin      = ctl_q.ir_in;
    assign bus.Yin       = ctl_q.y_in;
    assign bus.Zlowin    = ctl_q.zlow_in;
    assign bus.Zlowout   = ctl_q.zlow_out;
    assign bus.CSEout    = ctl_q.cse_out;
    assign bus.ADD       = ctl_q.add;
    assign bus.Gra       = ctl_q.gra;
    assign bus.Grb       = ctl_q.grb;
    assign bus.Rin       = ctl_q.r_in;
    assign bus.Rout      = ctl_q.r_out;
    assign bus.BAout     = ctl_q.ba_out;
    assign bus.done      = ctl_q.done;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;
    assign bus.step      = step_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Random-instruction bench for load_store_sequencer at MEM_WAIT = 0 and 2.
// Each instruction is expanded into its full expected cycle trace (strobes,
// done, step); a queue of those traces is replayed against the DUT cycle by
// cycle, with run/clear applied only where they take effect.
module tb_load_store_sequencer;

    localparam int N_CYC = 3000;

    localparam logic [19:0] M_PCOUT  = 20'h00001, M_PCIN  = 20'h00002, M_INCPC = 20'h00004;
    localparam logic [19:0] M_MARIN  = 20'h00008, M_MDRIN = 20'h00010, M_MDROUT = 20'h00020;
    localparam logic [19:0] M_MDMUX  = 20'h00040, M_RAMR  = 20'h00080, M_RAMW  = 20'h00100;
    localparam logic [19:0] M_IRIN   = 20'h00200, M_YIN   = 20'h00400, M_ZLI   = 20'h00800;
    localparam logic [19:0] M_ZLO    = 20'h01000, M_CSE   = 20'h02000, M_ADD   = 20'h04000;
    localparam logic [19:0] M_GRA    = 20'h08000, M_GRB   = 20'h10000, M_RIN   = 20'h20000;
    localparam logic [19:0] M_ROUT   = 20'h40000, M_BAOUT = 20'h80000;

    typedef struct packed {
        logic [19:0] s;
        logic        done;
        logic [3:0]  step;
        logic        set_ill;
        logic        enter_halt;
    } ent_t;

    logic clock = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int mw, input int cyc,
                       input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (MEM_WAIT=%0d cycle %0d): got %0h, want %0h", nm, mw, cyc, act, req);
        end
    endtask

    function automatic ent_t mk(input logic [19:0] s, input logic dn, input logic [3:0] st,
                                input logic il, input logic hl);
        ent_t e;
        e.s = s; e.done = dn; e.step = st; e.set_ill = il; e.enter_halt = hl;
        return e;
    endfunction

    function automatic logic [31:0] rand_ins();
        int r;
        logic [4:0] opc;
        logic [4:0] bad [3];
        bad = '{5'b11111, 5'b00011, 5'b10101};
        r = $urandom_range(0, 99);
        if (r < 25)      opc = 5'b00000;
        else if (r < 50) opc = 5'b00001;
        else if (r < 75) opc = 5'b00010;
        else if (r < 85) opc = 5'b11010;
        else if (r < 96) opc = bad[$urandom_range(0, 2)];
        else             opc = 5'b11011;
        return {opc, 27'($urandom())};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int MW = (g == 0) ? 0 : 2;

        logic        clear;
        logic        fin_l;
        logic [19:0] act;
        ent_t        q [$];

        load_store_sequencer_if #(.IR_WIDTH(32)) bus ();

        load_store_sequencer #(.IR_WIDTH(32), .MEM_WAIT(MW)) dut (
            .clock (clock),
            .clear (clear),
            .bus   (bus)
        );

        assign act = {bus.BAout, bus.Rout, bus.Rin, bus.Grb, bus.Gra, bus.ADD, bus.CSEout,
                      bus.Zlowout, bus.Zlowin, bus.Yin, bus.IRin, bus.RAMwrite, bus.RAMread,
                      bus.MDMuxread, bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC, bus.PCin,
                      bus.PCout};

        task automatic add(input logic [3:0] st, input logic [19:0] m, input logic dn,
                           input logic il, input logic hl);
            q.push_back(mk(m, dn, st, il, hl));
        endtask

        // Full cycle trace of one instruction, fetch included.
        task automatic build(input logic [31:0] ins);
            logic [4:0] opc;
            logic       is_mem;
            opc    = ins[31:27];
            is_mem = (opc == 5'b00000) || (opc == 5'b00001) || (opc == 5'b00010);
            add(4'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZLI, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i <= MW; i++)
                add(4'd1, M_MDMUX | M_RAMR | ((i == 0) ? (M_ZLO | M_PCIN) : 20'h0)
                          | ((i == MW) ? M_MDRIN : 20'h0), 1'b0, 1'b0, 1'b0);
            add(4'd2, M_MDROUT | M_IRIN, 1'b0, 1'b0, 1'b0);
            if (is_mem) begin
                add(4'd3, M_GRB | M_BAOUT | M_YIN, 1'b0, 1'b0, 1'b0);
                add(4'd4, M_CSE | M_ADD | M_ZLI, 1'b0, 1'b0, 1'b0);
                if (opc == 5'b00001) begin
                    add(4'd5, M_ZLO | M_GRA | M_RIN, 1'b1, 1'b0, 1'b0);
                end else begin
                    add(4'd5, M_ZLO | M_MARIN, 1'b0, 1'b0, 1'b0);
                    for (int i = 0; i <= MW; i++) begin
                        if (opc == 5'b00000)
                            add(4'd6, M_MDMUX | M_RAMR | ((i == MW) ? M_MDRIN : 20'h0),
                                1'b0, 1'b0, 1'b0);
                        else
                            add(4'd6, M_GRA | M_ROUT | M_RAMW, i == MW, 1'b0, 1'b0);
                    end
                    if (opc == 5'b00000) add(4'd7, M_MDROUT | M_GRA | M_RIN, 1'b1, 1'b0, 1'b0);
                end
            end else begin
                add(4'd3, 20'h0, 1'b1, (opc != 5'b11010) && (opc != 5'b11011), opc == 5'b11011);
            end
        endtask

        initial begin
            ent_t        cur;
            ent_t        idle_w;
            logic        m_ill, m_halt;
            int          halt_cnt, t, n_dir, dir_idx;
            int          done_at [$];
            logic [31:0] dir [3];
            int          exp_done [3];
            logic [31:0] ins;

            fin_l   = 1'b0;
            clear   = 1'b1;
            bus.run = 1'b0;
            bus.IR  = 32'h0;
            ins     = 32'h0;

            if (MW == 0) begin
                dir = '{32'h08800043, 32'h10800087, 32'h10880087};
                exp_done = '{6, 13, 20};
                n_dir = 3;
            end else begin
                dir = '{32'h01000087, 32'hF8000000, 32'h0};
                exp_done = '{12, 18, 0};
                n_dir = 2;
            end

            // Pin trace lengths of the model against hand-counted values.
            build(32'h08800043); chk("model_ldi_len", MW, 0, q.size(), 6 + MW); q.delete();
            build(32'h10800087); chk("model_st_len", MW, 0, q.size(), 7 + 2 * MW);
            chk("model_st_last", MW, 0, {q[q.size()-1].done, q[q.size()-1].s},
                {1'b1, M_GRA | M_ROUT | M_RAMW});
            q.delete();
            build(32'h01000087); chk("model_ld_len", MW, 0, q.size(), 8 + 2 * MW); q.delete();
            build(32'hD8000000); chk("model_halt_len", MW, 0, q.size(), 4 + MW); q.delete();

            idle_w   = mk(20'h0, 1'b0, 4'hF, 1'b0, 1'b0);
            cur      = idle_w;
            m_ill    = 1'b0;
            m_halt   = 1'b0;
            halt_cnt = 0;
            t        = 0;
            dir_idx  = 0;

            for (int it = 0; it < N_CYC; it++) begin
                @(posedge clock);
                #1;
                chk("strobes", MW, it, act, cur.s);
                chk("done", MW, it, bus.done, cur.done);
                chk("step", MW, it, bus.step, cur.step);
                chk("halted", MW, it, bus.halted, m_halt);
                chk("illegal", MW, it, bus.illegal, m_ill);
                chk("ram_rw_excl", MW, it, act[7] & act[8], 0);
                chk("gra_grb_excl", MW, it, act[15] & act[16], 0);

                if (t == 0 && it >= 2 && bus.step == 4'd0) t = 1;
                else if (t > 0) t++;
                if (t > 0 && bus.done && it < 32) done_at.push_back(t);
                if (it == 32)
                    for (int k = 0; k < n_dir; k++)
                        chk("done_cycle", MW, k, (done_at.size() > k) ? done_at[k] : -1,
                            exp_done[k]);

                if (m_halt) halt_cnt++; else halt_cnt = 0;
                if (bus.IRin) bus.IR = ins;

                if (it < 2) begin
                    clear = 1'b1; bus.run = 1'b0;
                end else if (it < 32) begin
                    clear = 1'b0; bus.run = 1'b1;
                end else begin
                    clear   = (m_halt && halt_cnt > 12) || ($urandom_range(0, 79) == 0);
                    bus.run = ($urandom_range(0, 5) != 0);
                end

                // Expectation for the cycle after the coming falling edge.
                if (clear) begin
                    q.delete(); m_ill = 1'b0; m_halt = 1'b0; cur = idle_w;
                end else if (m_halt) begin
                    cur = idle_w;
                end else if (cur.enter_halt) begin
                    m_halt = 1'b1; cur = idle_w;
                end else begin
                    if (q.size() == 0 && bus.run) begin
                        if (dir_idx < n_dir) begin ins = dir[dir_idx]; dir_idx++; end
                        else ins = rand_ins();
                        build(ins);
                        bus.IR = $urandom();
                    end
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        if (cur.set_ill) m_ill = 1'b1;
                    end else begin
                        cur = idle_w;
                    end
                end
            end
            fin_l = 1'b1;
        end
    end

    initial begin
        repeat (N_CYC + 20) @(posedge clock);
        chk("finished", 0, 0, {31'b0, g_dut[0].fin_l & g_dut[1].fin_l}, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
